gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 69 ++++++
 tb/tb_gray_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered, same-cycle Gray-code view and a one-cycle wrap pulse.
// Loads accept either binary or Gray-coded values; synchronous active-high reset.
module gray_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned RST_VAL = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_up,
   input  logic             i_load,
   input  logic             i_load_gray,
   input  logic [WIDTH-1:0] i_load_val,
   output logic [WIDTH-1:0] o_bin,
   output logic [WIDTH-1:0] o_gray,
   output logic             o_wrap
);

   localparam logic [WIDTH-1:0] RstBin  = RST_VAL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RstGray = RstBin ^ (RstBin >> 1);
   localparam logic [WIDTH-1:0] MaxVal  = {WIDTH{1'b1}};

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] load_bin;

   // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      load_bin = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         load_bin[i] = ^(i_load_val >> i);
      end
   end

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (i_load) begin
         count_d = i_load_gray ? load_bin : i_load_val;
      end else if (i_en) begin
         if (i_up) begin
            count_d = count_q + 1'b1;
            wrap_d  = (count_q == MaxVal);
         end else begin
            count_d = count_q - 1'b1;
            wrap_d  = (count_q == '0);
         end
      end
      gray_d = count_d ^ (count_d >> 1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_q <= RstBin;
         gray_q  <= RstGray;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         gray_q  <= gray_d;
         wrap_q  <= wrap_d;
      end
   end

   assign o_bin  = count_q;
   assign o_gray = gray_q;
   assign o_wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: directed vector table at WIDTH=4, hand sequences at WIDTH=9/RST_VAL=5,
// and a random run checked against a behavioural model on both instances.
module tb_gray_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, up, load, lg;
   logic [3:0] lv4;
   logic [8:0] lv9;
   logic [3:0] bin4, gray4;
   logic       wrap4;
   logic [8:0] bin9, gray9;
   logic       wrap9;

   gray_counter #(.WIDTH(4), .RST_VAL(0)) u_dut4 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load), .i_load_gray(lg),
      .i_load_val(lv4), .o_bin(bin4), .o_gray(gray4), .o_wrap(wrap4)
   );

   gray_counter #(.WIDTH(9), .RST_VAL(5)) u_dut9 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_load(load), .i_load_gray(lg),
      .i_load_val(lv9), .o_bin(bin9), .o_gray(gray9), .o_wrap(wrap9)
   );

   typedef struct {
      logic       rst, en, up, load, lg;
      logic [3:0] lv;
      logic [3:0] bin, gray;
      logic       wrap;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, e, u, l, g, input logic [3:0] v, b, gr, input logic w);
      vec_t t;
      t.rst = r; t.en = e; t.up = u; t.load = l; t.lg = g; t.lv = v;
      t.bin = b; t.gray = gr; t.wrap = w;
      vecs.push_back(t);
   endtask

   task automatic drive(input logic r, e, u, l, g, input logic [3:0] v4, input logic [8:0] v9);
      rst = r; en = e; up = u; load = l; lg = g; lv4 = v4; lv9 = v9;
      @(posedge clk);
      #1;
   endtask

   // Reference next state: returns {wrap, bin}.
   function automatic logic [32:0] model_next(input int w, input logic [31:0] cur, rstv,
                                              input logic r, e, u, l, g,
                                              input logic [31:0] v);
      logic [31:0] mx, b;
      mx = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      if (r) return {1'b0, rstv};
      if (l) begin
         if (!g) return {1'b0, v & mx};
         b = '0;
         b[w-1] = v[w-1];
         for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ v[i];
         return {1'b0, b};
      end
      if (!e) return {1'b0, cur};
      if (u) return {cur == mx, (cur + 32'd1) & mx};
      return {cur == 0, (cur - 32'd1) & mx};
   endfunction

   logic [3:0] gtab [16];

   initial begin
      logic [32:0] n4, n9;
      logic [31:0] m4, m9;
      logic [3:0]  pg4;
      logic [8:0]  pg9;
      logic        r, e, u, l, g;
      logic [3:0]  v4;
      logic [8:0]  v9;

      gtab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      add(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
      for (int i = 0; i < 16; i++) add(0, 1, 1, 0, 0, 4'h0, 4'((i + 1) % 16), gtab[i], i == 15);
      add(0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0);     // hold drops wrap
      add(1, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
      add(0, 1, 0, 0, 0, 4'h0, 4'hF, 4'h8, 1);     // down wrap
      add(0, 1, 0, 0, 0, 4'h0, 4'hE, 4'h9, 0);
      add(0, 0, 0, 1, 1, 4'hD, 4'h9, 4'hD, 0);     // Gray load
      add(0, 0, 0, 1, 0, 4'hD, 4'hD, 4'hB, 0);     // binary load
      add(0, 1, 1, 1, 0, 4'hF, 4'hF, 4'h8, 0);     // load beats count
      add(0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 1);
      add(1, 1, 1, 1, 0, 4'h7, 4'h0, 4'h0, 0);     // reset beats load
      add(0, 1, 1, 0, 0, 4'h0, 4'h1, 4'h1, 0);
      add(0, 1, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0);     // load 0: no wrap
      add(0, 1, 0, 0, 0, 4'h0, 4'hF, 4'h8, 1);
      add(0, 1, 1, 0, 0, 4'h0, 4'h0, 4'h0, 1);     // direction flips, no dead cycle
      add(0, 1, 0, 0, 0, 4'h0, 4'hF, 4'h8, 1);
      add(0, 1, 0, 1, 0, 4'hF, 4'hF, 4'h8, 0);     // load max: no wrap
      add(1, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);

      foreach (vecs[k]) begin
         drive(vecs[k].rst, vecs[k].en, vecs[k].up, vecs[k].load, vecs[k].lg, vecs[k].lv, 9'h0);
         chk($sformatf("vec%0d_bin", k), 32'(bin4), 32'(vecs[k].bin));
         chk($sformatf("vec%0d_gray", k), 32'(gray4), 32'(vecs[k].gray));
         chk($sformatf("vec%0d_wrap", k), 32'(wrap4), 32'(vecs[k].wrap));
      end

      // WIDTH=9, RST_VAL=5
      drive(1, 0, 0, 0, 0, 4'h0, 9'h0);
      chk("w9_rst_bin", 32'(bin9), 32'h5);
      chk("w9_rst_gray", 32'(gray9), 32'h7);
      chk("w9_rst_wrap", 32'(wrap9), 32'h0);
      drive(0, 1, 1, 0, 0, 4'h0, 9'h0);
      chk("w9_up_bin", 32'(bin9), 32'h6);
      chk("w9_up_gray", 32'(gray9), 32'h5);
      drive(0, 0, 0, 1, 1, 4'h0, 9'h1FF);
      chk("w9_lg_bin", 32'(bin9), 32'h155);
      chk("w9_lg_gray", 32'(gray9), 32'h1FF);
      drive(0, 1, 1, 0, 0, 4'h0, 9'h0);
      chk("w9_up2_bin", 32'(bin9), 32'h156);
      chk("w9_up2_gray", 32'(gray9), 32'h1FD);
      drive(1, 1, 1, 1, 0, 4'h0, 9'h0AA);
      chk("w9_rstld_bin", 32'(bin9), 32'h5);
      chk("w9_rstld_gray", 32'(gray9), 32'h7);

      // Random run, both widths, against the model.
      m4 = 0; m9 = 5; pg4 = gray4; pg9 = gray9;
      for (int c = 0; c < 10000; c++) begin
         r  = (c == 0) || ($urandom_range(63) == 0);
         l  = ($urandom_range(7) == 0);
         e  = ($urandom_range(3) != 0);
         u  = ($urandom_range(1) == 1);
         g  = ($urandom_range(1) == 1);
         v4 = 4'($urandom);
         v9 = 9'($urandom);
         n4 = model_next(4, m4, 32'd0, r, e, u, l, g, 32'(v4));
         n9 = model_next(9, m9, 32'd5, r, e, u, l, g, 32'(v9));
         drive(r, e, u, l, g, v4, v9);
         m4 = n4[31:0];
         m9 = n9[31:0];
         chk("rnd4_bin", 32'(bin4), m4);
         chk("rnd4_gray", 32'(gray4), m4 ^ (m4 >> 1));
         chk("rnd4_wrap", 32'(wrap4), 32'(n4[32]));
         chk("rnd9_bin", 32'(bin9), m9);
         chk("rnd9_gray", 32'(gray9), m9 ^ (m9 >> 1));
         chk("rnd9_wrap", 32'(wrap9), 32'(n9[32]));
         if (!r && !l && e) begin
            chk("rnd4_gray_1bit", 32'($countones(gray4 ^ pg4)), 32'd1);
            chk("rnd9_gray_1bit", 32'($countones(gray9 ^ pg9)), 32'd1);
         end
         pg4 = gray4;
         pg9 = gray9;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
